gpio_input_conditioner: RTL and testbench

- Conditions raw GPIO pad inputs before they reach the wb_gpio input register.
- Per-bit path: 2-flop synchronizer, then a debounce counter, then rising/falling edge detection, then sticky per-bit interrupt-pending flags.
- in_o feeds the GPIO block's input path. irq_o goes to the SoC interrupt line.
- Enables and clears come from a register block elsewhere, as level and pulse vectors.

---
 rtl/gpio_input_conditioner.sv | 114 +++++++++++
 tb/tb_gpio_input_conditioner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
//   Conditions raw GPIO pad levels before they reach the GPIO input register.
//   Each bit is handled on its own, in this order:
//     1. A 2-flop synchronizer.
//     2. A debounce counter. The synchronized level must persist for
//        debounce_cycles consecutive clocks before the stable level follows it.
//     3. One-cycle rise/fall pulses, registered at the same edge the stable
//        level changes.
//     4. Sticky interrupt-pending flags, with per-bit enables and clears.
//
// Ports
//   clk          single clock for all state
//   rst_n        asynchronous active-low reset
//   pin_i        raw pad levels (asynchronous to clk)
//   in_o         debounced stable level per bit
//   rise_o       one-cycle pulse on a debounced 0->1 change
//   fall_o       one-cycle pulse on a debounced 1->0 change
//   irq_en_rise  per-bit enable: a rise pulse sets pending
//   irq_en_fall  per-bit enable: a fall pulse sets pending
//   irq_clear    per-bit clear pulse for pending (a set in the same cycle wins)
//   irq_pending  sticky pending flags
//   irq_o        OR of all pending flags
module gpio_input_conditioner #(
  parameter int size            = 32,
  parameter int debounce_cycles = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [size-1:0] pin_i,
  output logic [size-1:0] in_o,
  output logic [size-1:0] rise_o,
  output logic [size-1:0] fall_o,
  input  logic [size-1:0] irq_en_rise,
  input  logic [size-1:0] irq_en_fall,
  input  logic [size-1:0] irq_clear,
  output logic [size-1:0] irq_pending,
  output logic            irq_o
);

  localparam int            CW       = $clog2(debounce_cycles + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(debounce_cycles - 1);

  logic [size-1:0] r_sync1;
  logic [size-1:0] r_sync2;

  // The synchronizer is the only logic that samples pin_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pin_i;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < size; gi++) begin : g_bit
      logic          r_stable;
      logic          r_rise;
      logic          r_fall;
      logic          r_pending;
      logic [CW-1:0] r_cnt;
      logic          w_differ;
      logic          w_done;
      logic          w_set;

      assign w_differ = r_sync2[gi] != r_stable;
      // The level has differed for debounce_cycles clocks, so this edge accepts it.
      assign w_done   = w_differ && (r_cnt == CNT_LAST);
      // The pending flag is set by the registered pulses, so it lags rise_o/fall_o by one cycle.
      assign w_set    = (r_rise & irq_en_rise[gi]) | (r_fall & irq_en_fall[gi]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_stable <= 1'b0;
          r_cnt    <= '0;
          r_rise   <= 1'b0;
          r_fall   <= 1'b0;
        end else begin
          r_rise <= w_done &  r_sync2[gi];
          r_fall <= w_done & ~r_sync2[gi];
          if (!w_differ) begin
            r_cnt <= '0;
          end else if (w_done) begin
            r_stable <= r_sync2[gi];
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pending <= 1'b0;
        end else if (w_set) begin
          r_pending <= 1'b1;
        end else if (irq_clear[gi]) begin
          r_pending <= 1'b0;
        end
      end

      assign in_o[gi]        = r_stable;
      assign rise_o[gi]      = r_rise;
      assign fall_o[gi]      = r_fall;
      assign irq_pending[gi] = r_pending;
    end
  endgenerate

  assign irq_o = |irq_pending;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner.
//   dut_a: size=8, debounce_cycles=4
//   dut_b: size=8, debounce_cycles=1
// Inputs are driven 1 time unit after a rising edge.
// Outputs are sampled at that same point, before any input change.
module tb_gpio_input_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] pin_a = '0, en_r_a = '0, en_f_a = '0, clr_a = '0;
  logic [7:0] in_a, rise_a, fall_a, pend_a;
  logic       irq_a;

  logic [7:0] pin_b = '0, en_r_b = '0, en_f_b = '0, clr_b = '0;
  logic [7:0] in_b, rise_b, fall_b, pend_b;
  logic       irq_b;

  gpio_input_conditioner #(.size(8), .debounce_cycles(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .pin_i(pin_a),
    .in_o(in_a), .rise_o(rise_a), .fall_o(fall_a),
    .irq_en_rise(en_r_a), .irq_en_fall(en_f_a), .irq_clear(clr_a),
    .irq_pending(pend_a), .irq_o(irq_a)
  );

  gpio_input_conditioner #(.size(8), .debounce_cycles(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pin_i(pin_b),
    .in_o(in_b), .rise_o(rise_b), .fall_o(fall_b),
    .irq_en_rise(en_r_b), .irq_en_fall(en_f_b), .irq_clear(clr_b),
    .irq_pending(pend_b), .irq_o(irq_b)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %s obs=%h exp=%h", tag, obs, exp);
    end else begin
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_in_a",   32'(in_a),   32'h00);
    check("rst_pend_a", 32'(pend_a), 32'h00);
    check("rst_irq_a",  32'(irq_a),  32'h0);
    check("rst_in_b",   32'(in_b),   32'h00);
    rst_n = 1'b1;
    repeat (3) tick();

    // Test 1: bit0 rises; in_o follows 5 edges after the first edge that sees it
    pin_a[0] = 1'b1;
    repeat (5) tick();
    check("t1_in_early",  32'(in_a),   32'h00);
    tick();
    check("t1_in",        32'(in_a),   32'h01);
    check("t1_rise",      32'(rise_a), 32'h01);
    tick();
    check("t1_rise_off",  32'(rise_a), 32'h00);
    check("t1_in_hold",   32'(in_a),   32'h01);

    // Test 2: 3-cycle glitch on bit1 is rejected
    en_r_a = 8'h02;
    pin_a[1] = 1'b1;
    repeat (3) tick();
    pin_a[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_glitch", 32'({in_a[1], rise_a[1], pend_a[1]}), 32'h0);
    end
    en_r_a = 8'h00;

    // Test 3: bit2 fall-only enable, then clear
    en_f_a = 8'h04;
    pin_a[2] = 1'b1;
    repeat (6) tick();
    check("t3_in_hi",   32'(in_a),   32'h05);
    check("t3_rise",    32'(rise_a), 32'h04);
    tick();
    check("t3_no_pend", 32'(pend_a), 32'h00);
    pin_a[2] = 1'b0;
    repeat (6) tick();
    check("t3_in_lo",   32'(in_a),   32'h01);
    check("t3_fall",    32'(fall_a), 32'h04);
    check("t3_pend0",   32'(pend_a), 32'h00);
    tick();
    check("t3_pend",    32'(pend_a), 32'h04);
    check("t3_irq",     32'(irq_a),  32'h1);
    check("t3_fall_off", 32'(fall_a), 32'h00);
    en_f_a = 8'h00;
    tick();
    check("t3_en_off_keep", 32'(pend_a), 32'h04);
    clr_a = 8'h04;
    tick();
    clr_a = 8'h00;
    check("t3_clr_pend", 32'(pend_a), 32'h00);
    check("t3_clr_irq",  32'(irq_a),  32'h0);

    // Test 4: clear coincident with a rise pulse; the set wins
    en_r_a = 8'h08;
    pin_a[3] = 1'b1;
    repeat (6) tick();
    check("t4_rise", 32'(rise_a), 32'h08);
    clr_a = 8'h08;
    tick();
    clr_a = 8'h00;
    check("t4_set_wins", 32'(pend_a), 32'h08);
    check("t4_irq",      32'(irq_a),  32'h1);
    en_r_a = 8'h00;
    clr_a = 8'h08;
    tick();
    clr_a = 8'h00;
    check("t4_clr", 32'(pend_a), 32'h00);

    // Test 5: reset partway through a debounce on bit4
    pin_a[4] = 1'b1;
    repeat (4) tick();
    check("t5_pre_in", 32'(in_a), 32'h09);
    rst_n = 1'b0;
    #1;
    check("t5_rst_in",   32'(in_a),   32'h00);
    check("t5_rst_rf",   32'({rise_a, fall_a}), 32'h0000);
    check("t5_rst_pend", 32'(pend_a), 32'h00);
    check("t5_rst_irq",  32'(irq_a),  32'h0);
    repeat (2) tick();
    check("t5_rst_hold", 32'(in_a), 32'h00);
    rst_n = 1'b1;
    repeat (5) tick();
    check("t5_in_early", 32'(in_a),   32'h00);
    tick();
    check("t5_in",       32'(in_a),   32'h19);
    check("t5_rise",     32'(rise_a), 32'h19);

    // Test 6: debounce_cycles=1, bits 5 and 6 together
    en_r_b = 8'h60;
    en_f_b = 8'h60;
    pin_b = 8'h60;
    repeat (2) tick();
    check("t6_in_early", 32'(in_b),   32'h00);
    tick();
    check("t6_in",       32'(in_b),   32'h60);
    check("t6_rise",     32'(rise_b), 32'h60);
    tick();
    check("t6_pend",     32'(pend_b), 32'h60);
    check("t6_irq",      32'(irq_b),  32'h1);
    check("t6_rise_off", 32'(rise_b), 32'h00);
    pin_b = 8'h00;
    repeat (3) tick();
    check("t6_fall",     32'(fall_b), 32'h60);
    check("t6_in_lo",    32'(in_b),   32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
